// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard/stall controller.
// The slave side is the controller; the master side is the pipeline datapath.
interface hazard_ctrl_if #(
    parameter int STAT_W = 16
) ();
    logic [4:0]        IdRs;
    logic [4:0]        IdRt;
    logic              IdUsesRs;
    logic              IdUsesRt;
    logic              ExMemRead;
    logic [4:0]        ExRt;
    logic              IdIsMulDiv;
    logic              IdBranchTaken;
    logic              ClrStats;
    logic              PcWrite;
    logic              IfIdWrite;
    logic              IfFlush;
    logic              IdExBubble;
    logic              MulDivStart;
    logic              MdBusy;
    logic [STAT_W-1:0] StallCycles;

    modport slave (
        input  IdRs, IdRt, IdUsesRs, IdUsesRt, ExMemRead, ExRt,
               IdIsMulDiv, IdBranchTaken, ClrStats,
        output PcWrite, IfIdWrite, IfFlush, IdExBubble, MulDivStart,
               MdBusy, StallCycles
    );

    modport master (
        output IdRs, IdRt, IdUsesRs, IdUsesRt, ExMemRead, ExRt,
               IdIsMulDiv, IdBranchTaken, ClrStats,
        input  PcWrite, IfIdWrite, IfFlush, IdExBubble, MulDivStart,
               MdBusy, StallCycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use stalls, multi-cycle
// mul/div hold in ID, taken-branch flush, and a saturating stall-cycle counter.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_RUN  | normal issue; load-use > mul/div start > branch flush > normal
//   S_BUSY | mul/div held in ID; stall while r_cnt != 0, release at r_cnt == 0
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 8,
    parameter int STAT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  io_hz
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // RUN entry cycle already counts as one stall cycle
    localparam logic [CNT_W-1:0]  MD_CNT_INIT = CNT_W'(MD_LATENCY - 1);
    localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [STAT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_if_flush;
    logic w_idex_bubble;
    logic w_md_start;
    logic w_md_busy;

    assign w_load_use = io_hz.ExMemRead && (io_hz.ExRt != 5'd0) &&
                        ((io_hz.IdUsesRs && (io_hz.IdRs == io_hz.ExRt)) ||
                         (io_hz.IdUsesRt && (io_hz.IdRt == io_hz.ExRt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_if_flush    = 1'b0;
        w_idex_bubble = 1'b0;
        w_md_start    = 1'b0;
        w_md_busy     = 1'b0;

        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                    end else if (io_hz.IdIsMulDiv) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_md_start    = 1'b1;
                        w_next_state  = S_BUSY;
                        w_next_cnt    = MD_CNT_INIT;
                    end else if (io_hz.IdBranchTaken) begin
                        w_if_flush    = 1'b1;
                    end
                end
                S_BUSY: begin
                    w_md_busy = 1'b1;
                    if (r_cnt != '0) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_next_cnt    = r_cnt - 1'b1;
                    end else begin
                        w_next_state  = S_RUN;
                    end
                end
                default: begin
                    w_next_state = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (io_hz.ClrStats) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != STAT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_hz.PcWrite     = w_pc_write;
    assign io_hz.IfIdWrite   = w_ifid_write;
    assign io_hz.IfFlush     = w_if_flush;
    assign io_hz.IdExBubble  = w_idex_bubble;
    assign io_hz.MulDivStart = w_md_start;
    assign io_hz.MdBusy      = w_md_busy;
    assign io_hz.StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (latency 4 / 4-bit stats, latency 1 /
// 16-bit stats) share stimulus and are compared against a cycle-count model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       uses_rs, uses_rt, ex_mr, md, br, clr;

    int n_checks = 0;
    int n_fails  = 0;

    // model: k = 0 issuing normally, k = 1..L cycles since a mul/div started
    int k[2]    = '{0, 0};
    int stat[2] = '{0, 0};
    int lat[2]  = '{4, 1};
    int smax[2] = '{15, 65535};
    logic [5:0] e_prev[2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.STAT_W(4))  bus_a ();
    hazard_ctrl_if #(.STAT_W(16)) bus_b ();

    assign bus_a.IdRs = id_rs;        assign bus_b.IdRs = id_rs;
    assign bus_a.IdRt = id_rt;        assign bus_b.IdRt = id_rt;
    assign bus_a.IdUsesRs = uses_rs;  assign bus_b.IdUsesRs = uses_rs;
    assign bus_a.IdUsesRt = uses_rt;  assign bus_b.IdUsesRt = uses_rt;
    assign bus_a.ExMemRead = ex_mr;   assign bus_b.ExMemRead = ex_mr;
    assign bus_a.ExRt = ex_rt;        assign bus_b.ExRt = ex_rt;
    assign bus_a.IdIsMulDiv = md;     assign bus_b.IdIsMulDiv = md;
    assign bus_a.IdBranchTaken = br;  assign bus_b.IdBranchTaken = br;
    assign bus_a.ClrStats = clr;      assign bus_b.ClrStats = clr;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(8), .STAT_W(4)) dut_a (
        .clk(clk), .rst(rst), .io_hz(bus_a)
    );
    hazard_ctrl #(.MD_LATENCY(1), .CNT_W(8), .STAT_W(16)) dut_b (
        .clk(clk), .rst(rst), .io_hz(bus_b)
    );

    logic [5:0] oa, ob;
    assign oa = {bus_a.PcWrite, bus_a.IfIdWrite, bus_a.IfFlush,
                 bus_a.IdExBubble, bus_a.MulDivStart, bus_a.MdBusy};
    assign ob = {bus_b.PcWrite, bus_b.IfIdWrite, bus_b.IfFlush,
                 bus_b.IdExBubble, bus_b.MulDivStart, bus_b.MdBusy};

    function automatic logic load_use();
        return ex_mr && (ex_rt != 5'd0) &&
               ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt));
    endfunction

    // {PcWrite, IfIdWrite, IfFlush, IdExBubble, MulDivStart, MdBusy}
    function automatic logic [5:0] exp_outs(input int d);
        if (rst)            return 6'b000100;
        if (k[d] == 0) begin
            if (load_use()) return 6'b000100;
            if (md)         return 6'b000110;
            if (br)         return 6'b111000;
            return 6'b110000;
        end
        if (k[d] < lat[d])  return 6'b000101;
        return 6'b110001;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input int d, input string tag);
        string      nm[6] = '{"PcWrite", "IfIdWrite", "IfFlush", "IdExBubble",
                              "MulDivStart", "MdBusy"};
        logic [5:0] e = exp_outs(d);
        logic [5:0] o = (d == 0) ? oa : ob;
        logic [15:0] s = (d == 0) ? 16'(bus_a.StallCycles) : bus_b.StallCycles;
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s.%s[%0d]", tag, nm[i], d), 16'(o[5-i]), 16'(e[5-i]));
        chk($sformatf("%s.StallCycles[%0d]", tag, d), s, 16'(stat[d]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            stat[d] = 0;
        end
    endtask

    // entered at posedge+1 with inputs applied; returns at next posedge+1
    task automatic cycle(input string tag);
        if (rst) model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            check_dut(d, tag);
            e_prev[d] = exp_outs(d);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                k[d] = 0;
                stat[d] = 0;
            end else begin
                if (clr) stat[d] = 0;
                else if (!e_prev[d][5] && stat[d] < smax[d]) stat[d]++;
                if (k[d] == 0) k[d] = e_prev[d][1] ? 1 : 0;
                else k[d] = (k[d] == lat[d]) ? 0 : k[d] + 1;
            end
        end
        #1;
    endtask

    task automatic drive(input int rs, input int rt, input logic urs, input logic urt,
                         input logic emr, input int ert, input logic m,
                         input logic b, input logic c);
        id_rs = 5'(rs); id_rt = 5'(rt); uses_rs = urs; uses_rt = urt;
        ex_mr = emr; ex_rt = 5'(ert); md = m; br = b; clr = c;
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) check_dut(d, tag);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;

        drive(8, 0, 1, 0, 1, 8, 0, 0, 0);   cycle("lu_stall");
        drive(8, 0, 1, 0, 0, 8, 0, 0, 0);   cycle("lu_release");
        chk("lu_stat", 16'(bus_a.StallCycles), 16'd1);
        drive(3, 8, 0, 1, 1, 8, 0, 0, 0);   cycle("lu_rt");
        drive(0, 0, 1, 0, 1, 0, 0, 0, 0);   cycle("r0_nostall");
        drive(8, 0, 0, 0, 1, 8, 0, 0, 0);   cycle("lu_unused");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);   cycle("clr");
        drive(1, 2, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle($sformatf("md_held%0d", i));
        drive(1, 2, 1, 1, 0, 0, 0, 0, 0);   cycle("md_after");

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);   cycle("br_alone");
        drive(5, 0, 1, 0, 1, 5, 1, 1, 0);   cycle("br_lu_md");
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);   cycle("md_over_br");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle($sformatf("br_busy%0d", i));

        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);   cycle("md_for_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle("busy_cnt3");
        pulse_rst("rst_busy");
        cycle("post_rst");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);   cycle("md_fresh");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle($sformatf("md_fresh_busy%0d", i));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);   cycle("clr_sat");
        drive(9, 0, 1, 0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle("sat_hold");
        chk("sat_value", 16'(bus_a.StallCycles), 16'd15);
        drive(9, 0, 1, 0, 1, 9, 0, 0, 1);   cycle("clr_vs_stall");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle("clr_done");
        chk("clr_value", 16'(bus_a.StallCycles), 16'd0);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 31) == 0));
            cycle($sformatf("rnd%0d", i));
            if ($urandom_range(0, 99) == 0) pulse_rst($sformatf("rnd_pulse%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
